lc3_int_priority_encoder: RTL and testbench
===========================================

Name: lc3_int_priority_encoder

Overview:
- Parametrised, registered priority encoder with pending latch, mask and grant handshake. Successor to the combinational LC-3 priority encoder.
- Collects N interrupt/device request lines and holds a per-line pending bit.
- Selects one eligible line by fixed or round-robin priority and presents its index to the LC-3 control unit. The index is held stable until acknowledged.

Parameters:
- N, 8, number of request lines (2..16).
- IW, 3, index width; N <= 2^IW.
- EDGE, 1, 1 = pending set on rising edge of req_in; 0 = pending set while req_in is high (level).
- RR, 0, 0 = fixed priority (index 0 highest); 1 = round-robin starting after the last granted index.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_in  in  N  request lines, synchronous to clk.
- mask  in  N  1 = line enabled for selection; does not affect pending capture.
- int_valid  out  1  grant outstanding; int_idx valid.
- int_idx  out  IW  index of granted line.
- int_ack  in  1  control unit accepts grant; sampled only while int_valid = 1.
- pending  out  N  current pending register.

Behaviour:
- Reset (async, rst_n = 0): pending = 0, req_q = 0, int_valid = 0, int_idx = 0, rr_ptr = 0, state = IDLE.
- Capture, every edge:
  - req_q <= req_in.
  - EDGE=1: set = req_in & ~req_q.
  - EDGE=0: set = req_in.
  - pending <= (pending & ~clr) | set.
  - Set wins over a clear on the same bit in the same cycle, so no event is lost.
  - A line high at reset release counts as a rising edge.
- Eligibility: elig = pending & mask.
  - Fixed mode: the selected line is the lowest set index.
  - RR mode: search indices rr_ptr, rr_ptr+1, ..., N-1, 0, ..., rr_ptr-1; first set bit wins.
- FSM:
  - IDLE: if elig != 0, int_idx <= selected, int_valid <= 1, go to GRANT. Otherwise stay. int_ack is ignored in IDLE.
  - GRANT: int_valid and int_idx are held constant. This holds even if the mask bit or req_in for that line drops; a grant is never withdrawn.
  - GRANT exit: on int_ack = 1, clr = one-hot(int_idx), int_valid <= 0, rr_ptr <= (int_idx == N-1) ? 0 : int_idx+1, go to IDLE.
- Latency:
  - req_in sampled high at edge t0 → pending set after t0 → int_valid = 1 after t0+1 (2 edges).
  - int_ack at edge t → int_valid = 0 after t.
  - Next grant is earliest after t+1: one mandatory idle cycle between grants.
- Level mode: if req_in is still high when ack clears the bit, set re-asserts it in the same edge, so the line stays pending.
- rr_ptr updates only on ack, and is unused when RR = 0.
- Non-power-of-two N: the index never exceeds N-1, and rr_ptr wraps N-1 → 0.
- Reset mid-GRANT clears everything immediately; an outstanding ack is lost by design.

Test Plan:
- Reset/latency, N=8, EDGE=1, RR=0:
  - Release reset with req_in = 0 → all outputs 0.
  - Pulse req_in[5] for 1 cycle at edge t0 → pending = 0x20 after t0, int_valid = 1 and int_idx = 5 after t0+1.
  - Ack → pending = 0, int_valid = 0.
- Fixed priority and mask:
  - pending = 0x2C with mask = 0xFF → grants in order 2, 3, 5, each with one idle cycle between grants.
  - With mask = 0xF3 → grant 5 first, then stop; pending = 0x0C remains.
- Round-robin, RR=1:
  - Hold pending lines 1, 4, 6, re-triggered after each ack → grant sequence 1, 4, 6, 1, 4.
  - rr_ptr wraps from 7 to 0 after a grant of 7.
- Simultaneous set/clear, EDGE=1:
  - A new rising edge on line 3 in the same cycle as int_ack for idx 3 → pending[3] stays 1 and line 3 is granted again after the idle cycle.
- Grant stability:
  - During GRANT idx 2, drop mask[2] and assert req_in[0] → int_idx stays 2 until ack, then idx 0 is granted.
  - Assert reset mid-GRANT → int_valid = 0 and pending = 0 asynchronously.
- Level mode, EDGE=0:
  - Hold req_in[1] high across ack → pending[1] stays 1 and grant 1 repeats every 2 cycles.
  - Deassert req_in[1], then ack → pending[1] = 0.

Source files
------------

// File: rtl/lc3_int_priority_encoder.sv
// rtl/lc3_int_priority_encoder.sv - registered interrupt priority encoder with pending latch, mask and grant handshake
module lc3_int_priority_encoder #(
  parameter int N    = 8,
  parameter int IW   = 3,
  parameter int EDGE = 1,
  parameter int RR   = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req_in,
  input  logic [N-1:0]  mask,
  output logic          int_valid,
  output logic [IW-1:0] int_idx,
  input  logic          int_ack,
  output logic [N-1:0]  pending
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [N-1:0]  req_q;
  logic [N-1:0]  set;
  logic [N-1:0]  clr;
  logic [N-1:0]  elig;
  logic [N-1:0]  rot;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] base;
  logic [IW-1:0] off;
  logic [IW-1:0] sel;
  logic [IW:0]   sum;

  // req_q resets to 0, so a line already high at reset release reads as a rising edge
  assign set  = (EDGE != 0) ? (req_in & ~req_q) : req_in;
  assign clr  = (state == GRANT && int_ack) ? (N'(1) << int_idx) : '0;
  assign elig = pending & mask;
  assign base = (RR != 0) ? rr_ptr : '0;

  // Rotate so the search start sits at bit 0, take the lowest set bit, then rotate the index back
  always_comb begin
    rot = N'({elig, elig} >> base);
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= (IW + 1)'(N)) sum = sum - (IW + 1)'(N);
    sel = sum[IW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_q     <= '0;
      pending   <= '0;
      int_valid <= 1'b0;
      int_idx   <= '0;
      rr_ptr    <= '0;
    end else begin
      req_q   <= req_in;
      pending <= (pending & ~clr) | set;
      case (state)
        IDLE: begin
          if (elig != '0) begin
            int_idx   <= sel;
            int_valid <= 1'b1;
            state     <= GRANT;
          end
        end
        GRANT: begin
          // Grant is never withdrawn; only an ack releases it
          if (int_ack) begin
            int_valid <= 1'b0;
            rr_ptr    <= (int_idx == IW'(N - 1)) ? '0 : int_idx + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_int_priority_encoder.sv
// tb/tb_lc3_int_priority_encoder.sv - directed bench for fixed, round-robin and level-mode encoders
module tb_lc3_int_priority_encoder;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] mask;
  logic       ack;

  logic       a_valid, b_valid, c_valid;
  logic [2:0] a_idx, b_idx, c_idx;
  logic [7:0] a_pend, b_pend, c_pend;

  int checks;
  int failures;

  lc3_int_priority_encoder #(.N(8), .IW(3), .EDGE(1), .RR(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_in(req), .mask(mask),
    .int_valid(a_valid), .int_idx(a_idx), .int_ack(ack), .pending(a_pend)
  );

  lc3_int_priority_encoder #(.N(8), .IW(3), .EDGE(1), .RR(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_in(req), .mask(mask),
    .int_valid(b_valid), .int_idx(b_idx), .int_ack(ack), .pending(b_pend)
  );

  lc3_int_priority_encoder #(.N(8), .IW(3), .EDGE(0), .RR(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .req_in(req), .mask(mask),
    .int_valid(c_valid), .int_idx(c_idx), .int_ack(ack), .pending(c_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req   = '0;
    ack   = 1'b0;
    mask  = 8'hFF;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic ack_a(input string tag);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check({tag, "_ackvalid"}, 32'(a_valid), 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    req      = '0;
    mask     = 8'hFF;
    ack      = 1'b0;

    // Reset and basic latency (fixed, edge)
    do_reset();
    check("rst_valid", 32'(a_valid), 32'd0);
    check("rst_idx",   32'(a_idx),   32'd0);
    check("rst_pend",  32'(a_pend),  32'd0);
    check("rst_rr_valid", 32'(b_valid), 32'd0);
    req = 8'h20;
    tick();
    check("lat_pend", 32'(a_pend), 32'h20);
    check("lat_valid0", 32'(a_valid), 32'd0);
    req = 8'h00;
    tick();
    check("lat_valid1", 32'(a_valid), 32'd1);
    check("lat_idx", 32'(a_idx), 32'd5);
    ack_a("lat");
    check("lat_pend_clr", 32'(a_pend), 32'h00);

    // Fixed priority over 0x2C
    do_reset();
    req = 8'h2C;
    tick();
    req = 8'h00;
    check("fix_pend", 32'(a_pend), 32'h2C);
    tick();
    check("fix_g0", 32'(a_idx), 32'd2);
    ack_a("fix0");
    check("fix_pend1", 32'(a_pend), 32'h28);
    tick();
    check("fix_g1v", 32'(a_valid), 32'd1);
    check("fix_g1", 32'(a_idx), 32'd3);
    ack_a("fix1");
    tick();
    check("fix_g2", 32'(a_idx), 32'd5);
    ack_a("fix2");
    check("fix_pend_end", 32'(a_pend), 32'h00);

    // Mask 0xF3 leaves lines 2 and 3 pending
    do_reset();
    mask = 8'hF3;
    req  = 8'h2C;
    tick();
    req = 8'h00;
    tick();
    check("msk_g0", 32'(a_idx), 32'd5);
    ack_a("msk");
    tick();
    tick();
    check("msk_stop", 32'(a_valid), 32'd0);
    check("msk_pend", 32'(a_pend), 32'h0C);

    // Grant stability against mask drop and higher-priority arrival
    do_reset();
    req = 8'h04;
    tick();
    req = 8'h00;
    tick();
    check("stb_g", 32'(a_idx), 32'd2);
    mask = 8'hFB;
    req  = 8'h01;
    tick();
    req = 8'h00;
    check("stb_hold_v", 32'(a_valid), 32'd1);
    check("stb_hold_i", 32'(a_idx), 32'd2);
    tick();
    check("stb_hold_i2", 32'(a_idx), 32'd2);
    ack_a("stb");
    check("stb_pend", 32'(a_pend), 32'h01);
    tick();
    check("stb_next", 32'(a_idx), 32'd0);
    check("stb_next_v", 32'(a_valid), 32'd1);

    // Reset asserted mid-grant acts without a clock edge
    do_reset();
    req = 8'h11;
    tick();
    req = 8'h00;
    tick();
    check("amid_g", 32'(a_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("amid_valid", 32'(a_valid), 32'd0);
    check("amid_pend", 32'(a_pend), 32'h00);

    // New edge on line 3 in the ack cycle for line 3
    do_reset();
    req = 8'h08;
    tick();
    req = 8'h00;
    tick();
    check("sim_g", 32'(a_idx), 32'd3);
    req = 8'h08;
    ack_a("sim");
    req = 8'h00;
    check("sim_pend", 32'(a_pend), 32'h08);
    tick();
    check("sim_regrant_v", 32'(a_valid), 32'd1);
    check("sim_regrant_i", 32'(a_idx), 32'd3);

    // Round-robin over lines 1, 4, 6 with retrigger on each ack
    do_reset();
    req = 8'h52;
    tick();
    req = 8'h00;
    tick();
    check("rr_g0", 32'(b_idx), 32'd1);
    req = 8'h02; ack = 1'b1; tick(); ack = 1'b0; req = 8'h00;
    check("rr_pend0", 32'(b_pend), 32'h52);
    tick();
    check("rr_g1", 32'(b_idx), 32'd4);
    req = 8'h10; ack = 1'b1; tick(); ack = 1'b0; req = 8'h00;
    tick();
    check("rr_g2", 32'(b_idx), 32'd6);
    req = 8'h40; ack = 1'b1; tick(); ack = 1'b0; req = 8'h00;
    tick();
    check("rr_g3", 32'(b_idx), 32'd1);
    req = 8'h02; ack = 1'b1; tick(); ack = 1'b0; req = 8'h00;
    tick();
    check("rr_g4", 32'(b_idx), 32'd4);
    check("rr_g4v", 32'(b_valid), 32'd1);

    // Round-robin pointer wrap 7 -> 0
    do_reset();
    req = 8'h40;
    tick();
    req = 8'h00;
    tick();
    check("wr_g6", 32'(b_idx), 32'd6);
    ack = 1'b1; tick(); ack = 1'b0;
    req = 8'h81;
    tick();
    req = 8'h00;
    tick();
    check("wr_g7", 32'(b_idx), 32'd7);
    req = 8'h02; ack = 1'b1; tick(); ack = 1'b0; req = 8'h00;
    check("wr_pend", 32'(b_pend), 32'h03);
    tick();
    check("wr_g0", 32'(b_idx), 32'd0);

    // Level mode: held request survives ack
    do_reset();
    req = 8'h02;
    tick();
    check("lvl_pend", 32'(c_pend), 32'h02);
    tick();
    check("lvl_g0", 32'(c_idx), 32'd1);
    for (int k = 0; k < 2; k++) begin
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("lvl_gap", 32'(c_valid), 32'd0);
      check("lvl_keep", 32'(c_pend), 32'h02);
      tick();
      check("lvl_rep_v", 32'(c_valid), 32'd1);
      check("lvl_rep_i", 32'(c_idx), 32'd1);
    end
    req = 8'h00;
    tick();
    check("lvl_drop_hold", 32'(c_pend), 32'h02);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("lvl_clr", 32'(c_pend), 32'h00);
    tick();
    check("lvl_idle", 32'(c_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
